// File: rtl/xoodyak_pkg.sv
// Shared types and constants for the Xoodyak command sequencer.
// Opmode values follow the core's encoding: bit3 = continue, [2:0] = op.
package xoodyak_pkg;
  localparam int TEXT_W = 192;
  localparam int KEY_W  = 128;
  localparam int TAG_W  = 128;
  localparam int AD_W   = 352;

  localparam logic [3:0] OP_IDLE    = 4'h0;
  localparam logic [3:0] OP_INIT    = 4'h1;
  localparam logic [3:0] OP_NONCE   = 4'h2;
  localparam logic [3:0] OP_ASSOC   = 4'h3;
  localparam logic [3:0] OP_CRYPT   = 4'h4;
  localparam logic [3:0] OP_DECRYPT = 4'h5;
  localparam logic [3:0] OP_SQUEEZE = 4'h6;
  localparam logic [3:0] OP_RATCHET = 4'h7;
  localparam logic [3:0] OP_CONT    = 4'h8;

  typedef enum logic [2:0] {
    XS_IDLE,
    XS_INIT,
    XS_NONCE,
    XS_ASSOC,
    XS_CRYPT_WAIT,
    XS_CRYPT,
    XS_SQUEEZE,
    XS_TAG
  } xs_state_t;

  function automatic logic is_phase(input xs_state_t s);
    return (s == XS_INIT) || (s == XS_NONCE) ||
           (s == XS_ASSOC) || (s == XS_CRYPT) ||
           (s == XS_SQUEEZE);
  endfunction
endpackage

// File: rtl/xoodyak_outbuf.sv
// One-entry valid/ready output register.
// A load on the same edge as a drain keeps the entry valid.
module xoodyak_outbuf
  import xoodyak_pkg::*;
#(
  parameter int W = TEXT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/xoodyak_sequencer.sv
// Command-level controller that drives the Xoodyak core through
// init/nonce/assoc/crypt/squeeze and streams text blocks and the tag.
module xoodyak_sequencer
  import xoodyak_pkg::*;
#(
  parameter int NBLK_W = 6
) (
  input  logic              eph1,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_decrypt,
  input  logic [NBLK_W-1:0] cmd_nblocks,
  input  logic [KEY_W-1:0]  cmd_key,
  input  logic [KEY_W-1:0]  cmd_nonce,
  input  logic [AD_W-1:0]   cmd_assodata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TEXT_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TEXT_W-1:0] out_data,
  output logic              tag_valid,
  input  logic              tag_ready,
  output logic [TAG_W-1:0]  tag,
  output logic              core_start,
  output logic [3:0]        core_opmode,
  output logic [TEXT_W-1:0] core_textin,
  output logic [KEY_W-1:0]  core_key,
  output logic [KEY_W-1:0]  core_nonce,
  output logic [AD_W-1:0]   core_assodata,
  input  logic [TEXT_W-1:0] core_textout,
  input  logic              core_finished,
  output logic              busy,
  output logic              err
);
  xs_state_t         r_state;
  xs_state_t         w_next;
  logic              r_start;
  logic              r_err;
  logic              r_dec;
  logic [NBLK_W-1:0] r_count;
  logic [NBLK_W-1:0] r_idx;
  logic [KEY_W-1:0]  r_key;
  logic [KEY_W-1:0]  r_nonce;
  logic [AD_W-1:0]   r_ad;
  logic [TEXT_W-1:0] r_textin;

  logic              w_cmd_acc;
  logic              w_in_acc;
  logic              w_crypt_done;
  logic              w_tag_load;
  logic              w_tag_done;
  logic              w_spurious;
  logic [NBLK_W-1:0] w_cnt_dec;
  logic [3:0]        w_opmode;

  assign cmd_ready    = (r_state == XS_IDLE);
  assign busy         = (r_state != XS_IDLE);
  assign in_ready     = (r_state == XS_CRYPT_WAIT) & ~out_valid;
  assign w_cmd_acc    = cmd_valid & cmd_ready;
  assign w_in_acc     = in_valid & in_ready;
  assign w_crypt_done = (r_state == XS_CRYPT) & core_finished;
  assign w_tag_load   = (r_state == XS_SQUEEZE) & core_finished;
  assign w_tag_done   = (~tag_valid | tag_ready) &
                        (~out_valid | out_ready);
  assign w_spurious   = core_finished &
                        ((r_state == XS_IDLE) ||
                         (r_state == XS_CRYPT_WAIT) ||
                         (r_state == XS_TAG));
  // Saturating decrement: the count never wraps below zero
  assign w_cnt_dec    = (r_count != '0) ?
                        r_count - NBLK_W'(1) : '0;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      XS_IDLE:
        if (w_cmd_acc) w_next = XS_INIT;
      XS_INIT:
        if (core_finished) w_next = XS_NONCE;
      XS_NONCE:
        if (core_finished) w_next = XS_ASSOC;
      XS_ASSOC:
        if (core_finished)
          w_next = (r_count != '0) ? XS_CRYPT_WAIT : XS_SQUEEZE;
      XS_CRYPT_WAIT:
        if (w_in_acc) w_next = XS_CRYPT;
      XS_CRYPT:
        if (core_finished)
          w_next = (w_cnt_dec != '0) ? XS_CRYPT_WAIT : XS_SQUEEZE;
      XS_SQUEEZE:
        if (core_finished) w_next = XS_TAG;
      XS_TAG:
        if (w_tag_done) w_next = XS_IDLE;
      default:
        w_next = XS_IDLE;
    endcase
  end

  always_comb begin
    w_opmode = OP_IDLE;
    unique case (r_state)
      XS_INIT:    w_opmode = OP_INIT;
      XS_NONCE:   w_opmode = OP_NONCE;
      XS_ASSOC:   w_opmode = OP_ASSOC;
      XS_CRYPT:   w_opmode = ((r_idx != '0) ? OP_CONT : OP_IDLE) |
                             (r_dec ? OP_DECRYPT : OP_CRYPT);
      XS_SQUEEZE: w_opmode = OP_SQUEEZE;
      default:    w_opmode = OP_IDLE;
    endcase
  end

  always_ff @(posedge eph1 or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= XS_IDLE;
      r_start  <= 1'b0;
      r_err    <= 1'b0;
      r_dec    <= 1'b0;
      r_count  <= '0;
      r_idx    <= '0;
      r_key    <= '0;
      r_nonce  <= '0;
      r_ad     <= '0;
      r_textin <= '0;
    end else begin
      r_state <= w_next;
      // Every phase entry is a real state change, so this is one cycle
      r_start <= (w_next != r_state) & is_phase(w_next);
      r_err   <= r_err | w_spurious;
      if (w_cmd_acc) begin
        r_dec   <= cmd_decrypt;
        r_count <= cmd_nblocks;
        r_idx   <= '0;
        r_key   <= cmd_key;
        r_nonce <= cmd_nonce;
        r_ad    <= cmd_assodata;
      end
      if (w_in_acc) r_textin <= in_data;
      if (w_crypt_done) begin
        r_count <= w_cnt_dec;
        r_idx   <= r_idx + NBLK_W'(1);
      end
    end
  end

  xoodyak_outbuf #(.W(TEXT_W)) u_text_buf (
    .clk     (eph1),
    .rst_n   (reset_n),
    .i_load  (w_crypt_done),
    .i_data  (core_textout),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (out_data)
  );

  xoodyak_outbuf #(.W(TAG_W)) u_tag_buf (
    .clk     (eph1),
    .rst_n   (reset_n),
    .i_load  (w_tag_load),
    .i_data  (core_textout[TAG_W-1:0]),
    .i_ready (tag_ready),
    .o_valid (tag_valid),
    .o_data  (tag)
  );

  assign core_start    = r_start;
  assign core_opmode   = w_opmode;
  assign core_textin   = r_textin;
  assign core_key      = r_key;
  assign core_nonce    = r_nonce;
  assign core_assodata = r_ad;
  assign err           = r_err;
endmodule
